// File: rtl/pe_stg_2.sv
// pe_stg_2: two-stage weight-stationary MAC processing element with double-buffered
// weights, per-lane saturating accumulators, psum chain pass-through and drain.
module pe_stg_2 #(
  parameter int DW    = 8,
  parameter int LANES = 2,
  parameter int ACC_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode_sel_in,
  input  logic                   w_load_in,
  input  logic                   w_swap_in,
  input  logic                   psu_clr_in,
  input  logic                   drain_in,
  input  logic                   left_valid_in,
  input  logic [DW-1:0]          left_in,
  output logic                   right_valid_out,
  output logic [DW-1:0]          right_out,
  input  logic                   top_valid_in,
  input  logic [LANES*ACC_W-1:0] top_in,
  output logic                   bottom_valid_out,
  output logic [LANES*ACC_W-1:0] bottom_out,
  output logic [LANES-1:0]       sat_out
);
  localparam int PW = 2*DW+1;

  localparam logic [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DW-1:0]    shd_w   [LANES];
  logic signed [DW-1:0]    act_w   [LANES];
  logic signed [PW-1:0]    prod    [LANES];
  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] acc_nxt [LANES];
  logic signed [ACC_W:0]   sum     [LANES];
  logic [LANES-1:0]        clamp;
  logic                    s1_vld;
  logic                    mac_en;
  logic signed [DW:0]      lext;

  assign mac_en = left_valid_in & ~mode_sel_in[1];

  // Mode 01 zero-extends the left operand so it multiplies as unsigned.
  assign lext = mode_sel_in[0] ? {1'b0, left_in}
                               : {left_in[DW-1], left_in};

  // One extra bit on the sum exposes overflow as a top-two-bit mismatch.
  always_comb begin
    clamp = '0;
    for (int i = 0; i < LANES; i++) begin
      sum[i]     = (ACC_W+1)'(acc[i]) + (ACC_W+1)'(prod[i]);
      acc_nxt[i] = acc[i];
      if (s1_vld) begin
        clamp[i] = sum[i][ACC_W] ^ sum[i][ACC_W-1];
        if (clamp[i])
          acc_nxt[i] = sum[i][ACC_W] ? ACC_MIN : ACC_MAX;
        else
          acc_nxt[i] = sum[i][ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      right_valid_out  <= 1'b0;
      right_out        <= '0;
      s1_vld           <= 1'b0;
      bottom_valid_out <= 1'b0;
      bottom_out       <= '0;
      sat_out          <= '0;
      for (int i = 0; i < LANES; i++) begin
        shd_w[i] <= '0;
        act_w[i] <= '0;
        prod[i]  <= '0;
        acc[i]   <= '0;
      end
    end else begin
      right_valid_out  <= left_valid_in;
      right_out        <= left_in;
      s1_vld           <= mac_en;
      bottom_valid_out <= drain_in | top_valid_in;
      if (!drain_in)
        bottom_out <= top_in;
      for (int i = 0; i < LANES; i++) begin
        // Load and swap together: active takes the old shadow.
        if (w_load_in)
          shd_w[i] <= top_in[i*DW +: DW];
        if (w_swap_in)
          act_w[i] <= shd_w[i];
        if (mac_en)
          prod[i] <= PW'(lext) * PW'(act_w[i]);
        if (drain_in)
          bottom_out[i*ACC_W +: ACC_W] <= acc_nxt[i];
        if (drain_in | psu_clr_in) begin
          acc[i]     <= '0;
          sat_out[i] <= 1'b0;
        end else begin
          acc[i] <= acc_nxt[i];
          if (clamp[i])
            sat_out[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_stg_2.sv
// tb_pe_stg_2: directed vector bench for pe_stg_2; default instance plus an
// ACC_W=17 instance sharing the same stimulus for the saturation cases.
module tb_pe_stg_2;
  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic        wl, ws, clr, dr, lv, tv;
  logic [7:0]  left;
  logic [47:0] top;

  logic        rv0, bv0, rv1, bv1;
  logic [7:0]  r0, r1;
  logic [47:0] b0;
  logic [33:0] b1;
  logic [1:0]  s0, s1;

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pe_stg_2 u0 (
    .clk(clk), .rst_n(rst_n), .mode_sel_in(mode),
    .w_load_in(wl), .w_swap_in(ws), .psu_clr_in(clr),
    .drain_in(dr), .left_valid_in(lv), .left_in(left),
    .right_valid_out(rv0), .right_out(r0),
    .top_valid_in(tv), .top_in(top),
    .bottom_valid_out(bv0), .bottom_out(b0), .sat_out(s0)
  );

  pe_stg_2 #(.DW(8), .LANES(2), .ACC_W(17)) u1 (
    .clk(clk), .rst_n(rst_n), .mode_sel_in(mode),
    .w_load_in(wl), .w_swap_in(ws), .psu_clr_in(clr),
    .drain_in(dr), .left_valid_in(lv), .left_in(left),
    .right_valid_out(rv1), .right_out(r1),
    .top_valid_in(tv), .top_in(top[33:0]),
    .bottom_valid_out(bv1), .bottom_out(b1), .sat_out(s1)
  );

  typedef struct {
    logic [1:0]  mode;
    logic        wl, ws, clr, dr, lv;
    logic [7:0]  left;
    logic        tv;
    logic [47:0] top;
    logic        bv;
    logic        ckb;
    logic [47:0] b;
    logic        ckr;
    logic        rv;
    logic [7:0]  r;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(
    logic [1:0] m, logic l, logic s, logic c, logic d,
    logic v, logic [7:0] x, logic t, logic [47:0] tp,
    logic ebv, logic ckb, logic [47:0] eb,
    logic ckr, logic erv, logic [7:0] er);
    vec_t o;
    o.mode = m; o.wl = l; o.ws = s; o.clr = c; o.dr = d;
    o.lv = v; o.left = x; o.tv = t; o.top = tp;
    o.bv = ebv; o.ckb = ckb; o.b = eb;
    o.ckr = ckr; o.rv = erv; o.r = er;
    return o;
  endfunction

  function automatic logic [47:0] pk(int a, int b);
    logic [23:0] x, y;
    x = a[23:0];
    y = b[23:0];
    return {y, x};
  endfunction

  function automatic logic [33:0] pk17(int a, int b);
    logic [16:0] x, y;
    x = a[16:0];
    y = b[16:0];
    return {y, x};
  endfunction

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    mode = 2'b00; wl = 0; ws = 0; clr = 0; dr = 0;
    lv = 0; left = '0; tv = 0; top = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(logic [7:0] x);
    idle(); lv = 1; left = x; cyc();
  endtask

  initial begin
    vec_t v;
    idle();
    rst_n = 0;
    tv = 1; top = 48'hA5A5_A5A5_A5A5; lv = 1; left = 8'h5A;
    cyc(); cyc();
    chk("rst rv", rv0, 0);
    chk("rst r", r0, 0);
    chk("rst bv", bv0, 0);
    chk("rst b", b0, 0);
    chk("rst sat", s0, 0);
    chk("rst b17", b1, 0);
    idle();
    rst_n = 1;
    cyc();

    // weight load/swap, signed stream, drain
    tab.push_back(mk(0,1,0,0,0,0,0,0,48'hFD05,0,0,0,0,0,0));
    tab.push_back(mk(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,2,0,0,0,0,0,1,1,2));
    tab.push_back(mk(0,0,0,0,0,1,2,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,2,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(30,-18),0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(0,0),0,0,0));
    // unsigned vs signed left; drain with product in stage 2
    tab.push_back(mk(0,1,0,0,0,0,0,0,48'hFF01,0,0,0,0,0,0));
    tab.push_back(mk(0,0,1,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(1,0,0,0,0,1,8'hFF,0,0,0,0,0,1,1,8'hFF));
    tab.push_back(mk(1,0,0,0,1,0,0,0,0,1,1,pk(255,-255),0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,8'hFF,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(-1,1),0,0,0));
    // psum pass-through, drain priority over top
    tab.push_back(mk(0,0,0,0,0,0,0,1,48'h123456_ABCDEF,
                     1,1,48'h123456_ABCDEF,0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,3,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,1,48'hFFFFFF_FFFFFF,
                     1,1,pk(3,-3),0,0,0));
    // clear discards product in stage 2
    tab.push_back(mk(0,0,0,0,0,1,5,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,1,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(0,0),0,0,0));
    // clear+drain outputs acc_next then clears
    tab.push_back(mk(0,0,0,0,0,1,2,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,7,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,1,1,0,0,0,0,1,1,pk(9,-9),0,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(0,0),0,0,0));
    // bypass mode: no products, in-flight product still lands
    tab.push_back(mk(2,0,0,0,0,1,9,0,0,0,0,0,1,1,9));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(0,0),0,0,0));
    tab.push_back(mk(0,0,0,0,0,1,4,0,0,0,0,0,0,0,0));
    tab.push_back(mk(2,0,0,0,0,1,100,0,0,0,0,0,1,1,100));
    tab.push_back(mk(3,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    tab.push_back(mk(0,0,0,0,1,0,0,0,0,1,1,pk(4,-4),0,0,0));

    for (int k = 0; k < tab.size(); k++) begin
      v = tab[k];
      mode = v.mode; wl = v.wl; ws = v.ws; clr = v.clr;
      dr = v.dr; lv = v.lv; left = v.left;
      tv = v.tv; top = v.top;
      cyc();
      chk($sformatf("v%0d bv", k), bv0, v.bv);
      if (v.ckb)
        chk($sformatf("v%0d bottom", k), b0, v.b);
      if (v.ckr) begin
        chk($sformatf("v%0d rv", k), rv0, v.rv);
        chk($sformatf("v%0d right", k), r0, v.r);
      end
    end

    // double buffer: swap mid-stream, drain+swap, load+swap
    idle(); wl = 1; top = 48'hFE03; cyc();
    idle(); ws = 1; cyc();
    feed(1);
    idle(); lv = 1; left = 1; wl = 1; top = 48'h0507; cyc();
    idle(); lv = 1; left = 1; ws = 1; cyc();
    feed(1);
    idle(); lv = 1; left = 1; wl = 1; top = 48'h0101; cyc();
    feed(1);
    idle(); dr = 1; ws = 1; cyc();
    chk("dbuf drain", b0, pk(30, 9));
    chk("dbuf bv", bv0, 1);
    idle(); wl = 1; ws = 1; top = 48'h0202; cyc();
    feed(1);
    idle(); cyc();
    idle(); dr = 1; cyc();
    chk("ld+swap old", b0, pk(1, 1));
    idle(); ws = 1; cyc();
    feed(1);
    idle(); cyc();
    idle(); dr = 1; cyc();
    chk("ld+swap new", b0, pk(2, 2));

    // saturation on the ACC_W=17 instance
    idle(); wl = 1; top = 48'h8080; cyc();
    idle(); ws = 1; cyc();
    for (int k = 0; k < 5; k++) feed(8'h80);
    idle(); cyc();
    chk("sat17 flag", s1, 2'b11);
    chk("sat24 flag", s0, 2'b00);
    idle(); dr = 1; cyc();
    chk("sat17 drain", b1, pk17(65535, 65535));
    chk("sat24 drain", b0, pk(81920, 81920));
    chk("sat17 bv", bv1, 1);
    chk("sat17 clr", s1, 2'b00);

    // reset mid-stream
    feed(2);
    feed(2);
    idle(); rst_n = 0; lv = 1; left = 5; tv = 1;
    top = 48'h777777_777777; cyc();
    chk("mid rst rv", rv0, 0);
    chk("mid rst r", r0, 0);
    chk("mid rst bv", bv0, 0);
    chk("mid rst b", b0, 0);
    chk("mid rst sat", s1, 0);
    rst_n = 1;
    idle(); cyc();
    idle(); wl = 1; top = 48'h0202; cyc();
    idle(); ws = 1; cyc();
    feed(4);
    idle(); cyc();
    idle(); dr = 1; cyc();
    chk("post rst drain", b0, pk(8, 8));
    chk("post rst bv", bv0, 1);
    idle(); cyc();
    chk("post rst bv low", bv0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
